// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared types and constants for the RTC bus controller.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: FSM state enum, default phase lengths, RTC_AD encodings, registered-output bundle.
package rtc_bus_pkg;

  localparam int RTC_W = 8;

  localparam int unsigned T_SETUP_DEF  = 2;
  localparam int unsigned T_STROBE_DEF = 8;
  localparam int unsigned T_HOLD_DEF   = 2;
  localparam int unsigned T_GAP_DEF    = 4;

  // Level on rtc_ad that tells the chip which half of the access is on the bus.
  localparam logic RTC_AD_ADDR = 1'b0;
  localparam logic RTC_AD_DATA = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STROBE,
    ST_A_HOLD,
    ST_GAP,
    ST_D_SETUP,
    ST_D_STROBE,
    ST_D_HOLD,
    ST_DONE
  } rtc_state_e;

  // Everything the FSM drives, kept together so it can be registered as one flop bank.
  typedef struct packed {
    logic             busy;
    logic             done;
    logic             cs_n;
    logic             rd_n;
    logic             wr_n;
    logic             ad;
    logic             oe;
    logic [RTC_W-1:0] ad_out;
  } bus_out_t;

  localparam bus_out_t BUS_OUT_RST = '{
    busy: 1'b0, done: 1'b0, cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
    ad: RTC_AD_DATA, oe: 1'b0, ad_out: '0
  };

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// rtc_bus_ctrl_if: CPU-side request/response signals plus the RTC chip pins.
// Latency: n/a (wiring only).
// Backpressure: busy from the slave; requests seen while busy are dropped.
// Modports: slave = controller side, master = requester/pin-model side.
interface rtc_bus_ctrl_if;
  import rtc_bus_pkg::*;

  logic             req;
  logic             act_rtc;
  logic [RTC_W-1:0] dir;
  logic             rw;
  logic [RTC_W-1:0] wr_data;
  logic [RTC_W-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             rtc_cs_n;
  logic             rtc_rd_n;
  logic             rtc_wr_n;
  logic             rtc_ad;
  logic [RTC_W-1:0] ad_out;
  logic             ad_oe;
  logic [RTC_W-1:0] ad_in;

  modport slave (
    input  req, act_rtc, dir, rw, wr_data, ad_in,
    output rd_data, busy, done, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, ad_out, ad_oe
  );

  modport master (
    output req, act_rtc, dir, rw, wr_data, ad_in,
    input  rd_data, busy, done, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, ad_out, ad_oe
  );

endinterface

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: 8-bit phase timer; load on phase entry, count down, flag the last cycle.
// Latency: expired is high in the Nth cycle after a load of N (N >= 1).
// Backpressure: none; load has priority over counting.
// Ports: clk, reset_n, load, load_val, expired.
module rtc_phase_timer
  import rtc_bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [RTC_W-1:0] load_val,
  output logic             expired
);

  logic [RTC_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of 1 means this is the final cycle of the phase.
  assign expired = (cnt_q == RTC_W'(1));

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: runs one RTC register access (address cycle, gap, data cycle) on the muxed AD bus.
// Latency: 2*(T_SETUP+T_STROBE+T_HOLD)+T_GAP busy cycles, then a one-cycle done pulse.
// Backpressure: busy is high during the access; req while busy or in DONE is dropped.
// Ports: clk, reset_n (async active-low), bus (rtc_bus_ctrl_if.slave). All outputs registered.
// Option: RTC_ADDR_SKIP_EN remembers the last register address and skips the address cycle on a repeat.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SETUP  = T_SETUP_DEF,
  parameter int unsigned T_STROBE = T_STROBE_DEF,
  parameter int unsigned T_HOLD   = T_HOLD_DEF,
  parameter int unsigned T_GAP    = T_GAP_DEF
) (
  input logic           clk,
  input logic           reset_n,
  rtc_bus_ctrl_if.slave bus
);

  rtc_state_e       state_q, state_d;
  logic [RTC_W-1:0] dir_q, dir_d;
  logic [RTC_W-1:0] wdat_q, wdat_d;
  logic             rw_q, rw_d;
  logic [RTC_W-1:0] rd_data_q, rd_data_d;
  bus_out_t         out_q, out_d;

  logic             tmr_load;
  logic [RTC_W-1:0] tmr_val;
  logic             tmr_exp;
  logic             accept;
  logic             skip_addr;

  assign accept = bus.req && bus.act_rtc && (state_q == ST_IDLE);

`ifdef RTC_ADDR_SKIP_EN
  logic [RTC_W-1:0] last_addr_q, last_addr_d;
  logic             last_vld_q, last_vld_d;

  assign skip_addr = last_vld_q && (bus.dir == last_addr_q);

  // The chip only holds an address once its address cycle has fully completed.
  always_comb begin
    last_addr_d = last_addr_q;
    last_vld_d  = last_vld_q;
    if (state_q == ST_A_HOLD && tmr_exp) begin
      last_addr_d = dir_q;
      last_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_addr_q <= '0;
      last_vld_q  <= 1'b0;
    end else begin
      last_addr_q <= last_addr_d;
      last_vld_q  <= last_vld_d;
    end
  end
`else
  assign skip_addr = 1'b0;
`endif

  rtc_phase_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept)  state_d = skip_addr ? ST_D_SETUP : ST_A_SETUP;
      ST_A_SETUP:  if (tmr_exp) state_d = ST_A_STROBE;
      ST_A_STROBE: if (tmr_exp) state_d = ST_A_HOLD;
      ST_A_HOLD:   if (tmr_exp) state_d = ST_GAP;
      ST_GAP:      if (tmr_exp) state_d = ST_D_SETUP;
      ST_D_SETUP:  if (tmr_exp) state_d = ST_D_STROBE;
      ST_D_STROBE: if (tmr_exp) state_d = ST_D_HOLD;
      ST_D_HOLD:   if (tmr_exp) state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Reload the timer on every state change with the length of the state being entered.
  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_A_SETUP, ST_D_SETUP:   tmr_val = RTC_W'(T_SETUP);
      ST_A_STROBE, ST_D_STROBE: tmr_val = RTC_W'(T_STROBE);
      ST_A_HOLD, ST_D_HOLD:     tmr_val = RTC_W'(T_HOLD);
      ST_GAP:                   tmr_val = RTC_W'(T_GAP);
      default:                  tmr_val = '0;
    endcase
  end

  // Request latch and read capture. ad_in is taken on the edge that ends the read strobe.
  always_comb begin
    dir_d     = dir_q;
    rw_d      = rw_q;
    wdat_d    = wdat_q;
    rd_data_d = rd_data_q;
    if (accept) begin
      dir_d  = bus.dir;
      rw_d   = bus.rw;
      wdat_d = bus.wr_data;
    end
    if (state_q == ST_D_STROBE && tmr_exp && rw_q) begin
      rd_data_d = bus.ad_in;
    end
  end

  // Output logic: decoded from the next state so the pins are registered yet aligned with the state.
  // Uses the *_d request fields so the first A_SETUP cycle already drives the new address.
  always_comb begin
    out_d = BUS_OUT_RST;
    case (state_d)
      ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
        out_d.busy   = 1'b1;
        out_d.cs_n   = 1'b0;
        out_d.ad     = RTC_AD_ADDR;
        out_d.oe     = 1'b1;
        out_d.ad_out = dir_d;
        out_d.wr_n   = (state_d != ST_A_STROBE);
      end
      ST_GAP: begin
        out_d.busy = 1'b1;
      end
      ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
        out_d.busy   = 1'b1;
        out_d.cs_n   = 1'b0;
        out_d.ad     = RTC_AD_DATA;
        out_d.oe     = !rw_d;
        out_d.ad_out = rw_d ? '0 : wdat_d;
        if (state_d == ST_D_STROBE) begin
          out_d.rd_n = !rw_d;
          out_d.wr_n = rw_d;
        end
      end
      ST_DONE: begin
        out_d.done = 1'b1;
      end
      default: out_d = BUS_OUT_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q     <= '0;
      rw_q      <= 1'b0;
      wdat_q    <= '0;
      rd_data_q <= '0;
      out_q     <= BUS_OUT_RST;
    end else begin
      dir_q     <= dir_d;
      rw_q      <= rw_d;
      wdat_q    <= wdat_d;
      rd_data_q <= rd_data_d;
      out_q     <= out_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.busy     = out_q.busy;
  assign bus.done     = out_q.done;
  assign bus.rtc_cs_n = out_q.cs_n;
  assign bus.rtc_rd_n = out_q.rd_n;
  assign bus.rtc_wr_n = out_q.wr_n;
  assign bus.rtc_ad   = out_q.ad;
  assign bus.ad_oe    = out_q.oe;
  assign bus.ad_out   = out_q.ad_out;

endmodule
